// File: rtl/mem_bus_pkg.sv
// Shared definitions for mem_bus_if: FSM state encoding, bus direction and
// active-low strobe levels, and the SPM region selector.
`timescale 1ns/1ps
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACCESS = 2'd2,
    WAIT   = 2'd3
  } state_e;

  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam logic [2:0] SPM_REGION = 3'b011;

endpackage

// File: rtl/mem_bus_if.sv
// Per-stage memory front-end: zero-wait SPM accesses, req/grant/ready bus accesses.
// Optional bus access timeout with bus_err output: define MEM_BUS_IF_TIMEOUT_EN.
`timescale 1ns/1ps
module mem_bus_if
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W     = 30,
  parameter int DATA_W     = 32,
  parameter int SPM_ADDR_W = 12
`ifdef MEM_BUS_IF_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 255
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [ADDR_W-1:0]     addr,
  input  logic                  as_,
  input  logic                  rw,
  input  logic [DATA_W-1:0]     wr_data,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  busy,
  output logic [SPM_ADDR_W-1:0] spm_addr,
  output logic                  spm_as_,
  output logic                  spm_rw,
  output logic [DATA_W-1:0]     spm_wr_data,
  input  logic [DATA_W-1:0]     spm_rd_data,
  output logic                  bus_req_,
  input  logic                  bus_grnt_,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic                  bus_as_,
  output logic                  bus_rw,
  output logic [DATA_W-1:0]     bus_wr_data,
  input  logic [DATA_W-1:0]     bus_rd_data,
  input  logic                  bus_rdy_,
`ifdef MEM_BUS_IF_TIMEOUT_EN
  output logic                  bus_err,
`endif
  output state_e                dbg_state
);

  state_e              state_q, state_d;
  logic                bus_req_q, bus_req_d;
  logic                bus_as_q, bus_as_d;
  logic                bus_rw_q, bus_rw_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]   bus_wr_data_q, bus_wr_data_d;
  logic [ADDR_W-1:0]   lat_addr_q, lat_addr_d;
  logic                lat_rw_q, lat_rw_d;
  logic [DATA_W-1:0]   lat_wr_data_q, lat_wr_data_d;
  logic [DATA_W-1:0]   rd_buf_q, rd_buf_d;
  logic                spm_hit;
  logic                new_access;

`ifdef MEM_BUS_IF_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0]    tmo_q, tmo_d;
`endif

  // A strobe only counts as a new access in IDLE; reset also masks it so the
  // stage never sees busy while reset is held.
  assign spm_hit    = (addr[ADDR_W-1 -: 3] == SPM_REGION);
  assign new_access = reset && (as_ == ENABLE_) && !flush && (state_q == IDLE);

  assign spm_addr    = addr[SPM_ADDR_W-1:0];
  assign spm_rw      = rw;
  assign spm_wr_data = wr_data;
  assign spm_as_     = (new_access && spm_hit) ? ENABLE_ : DISABLE_;

  assign bus_req_    = bus_req_q;
  assign bus_as_     = bus_as_q;
  assign bus_rw      = bus_rw_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wr_data = bus_wr_data_q;
  assign dbg_state   = state_q;

  always_comb begin
    state_d       = state_q;
    bus_req_d     = bus_req_q;
    bus_as_d      = DISABLE_;
    bus_rw_d      = bus_rw_q;
    bus_addr_d    = bus_addr_q;
    bus_wr_data_d = bus_wr_data_q;
    lat_addr_d    = lat_addr_q;
    lat_rw_d      = lat_rw_q;
    lat_wr_data_d = lat_wr_data_q;
    rd_buf_d      = rd_buf_q;
    busy          = 1'b0;
    rd_data       = spm_rd_data;
`ifdef MEM_BUS_IF_TIMEOUT_EN
    tmo_d         = tmo_q;
    bus_err       = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (new_access && !spm_hit) begin
          busy          = 1'b1;
          bus_req_d     = ENABLE_;
          lat_addr_d    = addr;
          lat_rw_d      = rw;
          lat_wr_data_d = wr_data;
          state_d       = REQ;
        end
      end
      REQ: begin
        busy    = 1'b1;
        rd_data = rd_buf_q;
        if (bus_grnt_ == ENABLE_) begin
          bus_as_d      = ENABLE_;
          bus_addr_d    = lat_addr_q;
          bus_rw_d      = lat_rw_q;
          bus_wr_data_d = lat_wr_data_q;
          state_d       = ACCESS;
`ifdef MEM_BUS_IF_TIMEOUT_EN
          tmo_d         = '0;
`endif
        end
      end
      ACCESS: begin
        busy    = 1'b1;
        rd_data = bus_rd_data;
        if (bus_rdy_ == ENABLE_) begin
          busy      = 1'b0;
          bus_req_d = DISABLE_;
          if (lat_rw_q == READ) rd_buf_d = bus_rd_data;
          state_d   = stall ? WAIT : IDLE;
        end
`ifdef MEM_BUS_IF_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TIMEOUT_CYC)) begin
          busy      = 1'b0;
          rd_data   = '0;
          bus_err   = 1'b1;
          bus_req_d = DISABLE_;
          if (stall) begin
            rd_buf_d = '0;
            state_d  = WAIT;
          end else begin
            state_d  = IDLE;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      WAIT: begin
        rd_data = rd_buf_q;
        if (!stall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      bus_req_q     <= DISABLE_;
      bus_as_q      <= DISABLE_;
      bus_rw_q      <= READ;
      bus_addr_q    <= '0;
      bus_wr_data_q <= '0;
      lat_addr_q    <= '0;
      lat_rw_q      <= READ;
      lat_wr_data_q <= '0;
      rd_buf_q      <= '0;
`ifdef MEM_BUS_IF_TIMEOUT_EN
      tmo_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      bus_req_q     <= bus_req_d;
      bus_as_q      <= bus_as_d;
      bus_rw_q      <= bus_rw_d;
      bus_addr_q    <= bus_addr_d;
      bus_wr_data_q <= bus_wr_data_d;
      lat_addr_q    <= lat_addr_d;
      lat_rw_q      <= lat_rw_d;
      lat_wr_data_q <= lat_wr_data_d;
      rd_buf_q      <= rd_buf_d;
`ifdef MEM_BUS_IF_TIMEOUT_EN
      tmo_q         <= tmo_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_bus_if.sv
// Bench for mem_bus_if: random SPM/bus traffic against a memory reference model,
// bus slave with configurable grant/ready delays, queue-based output monitor.
`timescale 1ns/1ps
module tb_mem_bus_if;
  import mem_bus_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush, as_, rw;
  logic [29:0] addr;
  logic [31:0] wr_data, rd_data, spm_wr_data, spm_rd_data;
  logic [31:0] bus_wr_data, bus_rd_data;
  logic        busy, spm_as_, spm_rw, bus_req_, bus_grnt_, bus_as_, bus_rw, bus_rdy_;
  logic [11:0] spm_addr;
  logic [29:0] bus_addr;
  state_e      dbg_state;
`ifdef MEM_BUS_IF_TIMEOUT_EN
  logic        bus_err;
`endif

  always #5 clk = ~clk;

  mem_bus_if #(
    .ADDR_W(30), .DATA_W(32), .SPM_ADDR_W(12)
`ifdef MEM_BUS_IF_TIMEOUT_EN
    , .TIMEOUT_CYC(8)
`endif
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .addr(addr),
    .as_(as_), .rw(rw), .wr_data(wr_data), .rd_data(rd_data), .busy(busy),
    .spm_addr(spm_addr), .spm_as_(spm_as_), .spm_rw(spm_rw),
    .spm_wr_data(spm_wr_data), .spm_rd_data(spm_rd_data),
    .bus_req_(bus_req_), .bus_grnt_(bus_grnt_), .bus_addr(bus_addr),
    .bus_as_(bus_as_), .bus_rw(bus_rw), .bus_wr_data(bus_wr_data),
    .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_),
`ifdef MEM_BUS_IF_TIMEOUT_EN
    .bus_err(bus_err),
`endif
    .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // Expected queues: bus cycle {addr,rw,wdata}, completion {rw,rdata},
  // SPM strobe {spm_addr,rw,wdata,spm_rd_data}.
  logic [62:0] bus_exp_q[$];
  logic [32:0] rd_exp_q[$];
  logic [76:0] spm_exp_q[$];

  logic [31:0] ref_mem   [logic [29:0]];
  logic [31:0] slave_mem [logic [29:0]];
  logic [31:0] last_rd;
  int          slv_gd, slv_rdl;
  bit          slv_nordy;

  function automatic logic [31:0] init_pat(input logic [29:0] a);
    return {2'b00, a} ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [29:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_pat(a);
  endfunction

  function automatic logic [31:0] slave_rd(input logic [29:0] a);
    return slave_mem.exists(a) ? slave_mem[a] : init_pat(a);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Bus slave: grant after slv_gd cycles, ready slv_rdl cycles after the strobe.
  initial begin : bus_slave
    logic [29:0] sa;
    logic        sr;
    int          k;
    bus_grnt_ = 1'b1; bus_rdy_ = 1'b1; bus_rd_data = '0;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && bus_req_ === 1'b0) begin
        @(posedge clk); #1;
        repeat (slv_gd) begin @(posedge clk); #1; end
        bus_grnt_ = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (bus_as_ !== 1'b0 && k < 20);
        sa = bus_addr; sr = bus_rw;
        if (sr == WRITE) slave_mem[sa] = bus_wr_data;
        @(posedge clk); #1; bus_grnt_ = 1'b1;
        if (slv_nordy) begin
          k = 0;
          do begin @(negedge clk); k++; end while (bus_req_ !== 1'b1 && k < 40);
        end else begin
          repeat (slv_rdl) begin @(posedge clk); #1; end
          bus_rd_data = (sr == READ) ? slave_rd(sa) : $urandom;
          bus_rdy_ = 1'b0;
          @(posedge clk); #1;
          bus_rdy_ = 1'b1; bus_rd_data = $urandom;
        end
      end
    end
  end

  // Monitor: pops and compares whenever the DUT strobes SPM, strobes the bus or completes.
  initial begin : monitor
    logic prev_as, prev_done;
    logic [62:0] be;
    logic [32:0] re;
    logic [76:0] se;
    prev_as = 1'b0; prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        if (prev_as)   chk("bus_as_one_cycle", bus_as_, DISABLE_);
        if (prev_done) chk("bus_req_release", bus_req_, DISABLE_);
        prev_as   = (bus_as_ === 1'b0);
        prev_done = (bus_req_ === 1'b0 && bus_rdy_ === 1'b0);
        if (bus_as_ === 1'b0) begin
          if (bus_exp_q.size() == 0) chk("bus_as_unexpected", bus_as_, DISABLE_);
          else begin
            be = bus_exp_q.pop_front();
            chk("bus_addr", bus_addr, be[62:33]);
            chk("bus_rw", bus_rw, be[32]);
            if (be[32] == WRITE) chk("bus_wr_data", bus_wr_data, be[31:0]);
          end
        end
        if (prev_done) begin
          if (rd_exp_q.size() == 0) chk("done_unexpected", bus_rdy_, DISABLE_);
          else begin
            re = rd_exp_q.pop_front();
            chk("done_busy", busy, 0);
            if (re[32] == READ) chk("done_rd_data", rd_data, re[31:0]);
          end
        end
        if (spm_as_ === 1'b0) begin
          if (spm_exp_q.size() == 0) chk("spm_as_unexpected", spm_as_, DISABLE_);
          else begin
            se = spm_exp_q.pop_front();
            chk("spm_addr", spm_addr, se[76:65]);
            chk("spm_rw", spm_rw, se[64]);
            chk("spm_wr_data", spm_wr_data, se[63:32]);
            chk("spm_rd_data", rd_data, se[31:0]);
            chk("spm_busy", busy, 0);
            chk("spm_no_bus_req", bus_req_, DISABLE_);
          end
        end
      end else begin
        prev_as = 1'b0; prev_done = 1'b0;
      end
    end
  end

  task automatic spm_txn(input logic [29:0] a, input logic r, input logic [31:0] wd);
    logic [31:0] sd;
    sd = $urandom;
    @(posedge clk); #1;
    addr = a; rw = r; wr_data = wd; as_ = 1'b0; spm_rd_data = sd;
    spm_exp_q.push_back({a[11:0], r, wd, sd});
    @(posedge clk); #1; as_ = 1'b1;
  endtask

  task automatic bus_txn(input logic [29:0] a, input logic r, input logic [31:0] wd,
                         input int gd, input int rdl, input int st_hold, input bit fl_mid);
    logic [31:0] exp_d;
    int n;
    if (r == READ) begin exp_d = ref_rd(a); last_rd = exp_d; end
    else begin ref_mem[a] = wd; exp_d = '0; end
    bus_exp_q.push_back({a, r, wd});
    rd_exp_q.push_back({r, exp_d});
    slv_gd = gd; slv_rdl = rdl;
    @(posedge clk); #1;
    addr = a; rw = r; wr_data = wd; as_ = 1'b0; stall = (st_hold > 0);
    n = 0;
    do begin
      @(negedge clk); n++;
      if (fl_mid && n == 2) flush = 1'b1;
    end while (busy === 1'b1 && n < 60);
    chk("bus_latency", n, 5 + gd + rdl);
    @(posedge clk); #1; as_ = 1'b1; flush = 1'b0;
    if (st_hold > 0) begin
      for (int i = 0; i < st_hold; i++) begin
        @(negedge clk);
        chk("wait_state", dbg_state, WAIT);
        chk("wait_busy", busy, 0);
        chk("wait_rd_data", rd_data, last_rd);
      end
      @(posedge clk); #1; stall = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("wait_exit", dbg_state, IDLE);
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int tb;
    int k;
    int st;
    logic [29:0] a;
    reset = 1'b0; stall = 1'b0; flush = 1'b0; as_ = 1'b1; rw = 1'b1;
    addr = '0; wr_data = '0; spm_rd_data = 32'h1234_5678;
    slv_gd = 0; slv_rdl = 0; slv_nordy = 1'b0; last_rd = '0;
    ref_mem[30'h100]   = 32'hDEAD_BEEF;
    slave_mem[30'h100] = 32'hDEAD_BEEF;

    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_rd_data", rd_data, 32'h1234_5678);
    chk("rst_bus_req", bus_req_, DISABLE_);
    chk("rst_bus_as", bus_as_, DISABLE_);
    chk("rst_bus_rw", bus_rw, READ);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_wr_data", bus_wr_data, 0);
    chk("rst_spm_as", spm_as_, DISABLE_);
    chk("rst_state", dbg_state, IDLE);
    @(posedge clk); #2; reset = 1'b1;

    spm_txn(30'h1800_0010, READ, 32'h0);
    bus_txn(30'h100, READ, 32'h0, 2, 3, 0, 1'b0);
    bus_txn(30'h100, READ, 32'h0, 2, 3, 4, 1'b0);
    bus_txn(30'h200, WRITE, 32'hCAFE_F00D, 1, 1, 2, 1'b0);
    bus_txn(30'h200, READ, 32'h0, 0, 0, 0, 1'b1);

    // flush in IDLE blocks both a bus-region and an SPM-region access
    @(posedge clk); #1;
    addr = 30'h0000_0300; as_ = 1'b0; flush = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("flush_busy", busy, 0);
      chk("flush_bus_req", bus_req_, DISABLE_);
      chk("flush_spm_as", spm_as_, DISABLE_);
    end
    @(posedge clk); #1; addr = 30'h1800_0020;
    @(negedge clk);
    chk("flush_spm_hit_as", spm_as_, DISABLE_);
    @(posedge clk); #1; as_ = 1'b1; flush = 1'b0;

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 9) < 4) begin
        spm_txn({SPM_REGION, 27'($urandom)}, 1'($urandom), $urandom);
      end else begin
        tb = $urandom_range(0, 6);
        if (tb >= 3) tb++;
        a  = {tb[2:0], 23'd0, 4'($urandom_range(0, 15))};
        st = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
        bus_txn(a, 1'($urandom), $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                st, $urandom_range(0, 4) == 0);
      end
    end

    // reset while the bus access is outstanding
    slv_gd = 0; slv_rdl = 12;
    bus_exp_q.push_back({30'h55, READ, 32'h0});
    @(posedge clk); #1;
    addr = 30'h55; rw = READ; as_ = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (bus_as_ !== 1'b0 && k < 30);
    chk("rst_mid_reached_access", bus_as_, ENABLE_);
    @(posedge clk); #3; reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_bus_req", bus_req_, DISABLE_);
    chk("rst_mid_bus_as", bus_as_, DISABLE_);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_state", dbg_state, IDLE);
    as_ = 1'b1; last_rd = '0;
    @(posedge clk); #2; reset = 1'b1;
    repeat (16) @(posedge clk);

`ifdef MEM_BUS_IF_TIMEOUT_EN
    slv_gd = 1; slv_nordy = 1'b1;
    bus_exp_q.push_back({30'h77, READ, 32'h0});
    @(posedge clk); #1;
    addr = 30'h77; rw = READ; as_ = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (busy === 1'b1 && k < 60);
    chk("tmo_latency", k, 12 + 1);
    chk("tmo_bus_err", bus_err, 1);
    chk("tmo_rd_data", rd_data, 0);
    @(posedge clk); #1; as_ = 1'b1;
    @(negedge clk);
    chk("tmo_bus_err_pulse", bus_err, 0);
    chk("tmo_bus_req", bus_req_, DISABLE_);
    repeat (4) @(posedge clk);
    slv_nordy = 1'b0;
`endif

    repeat (5) @(negedge clk);
    chk("bus_exp_q_drained", bus_exp_q.size(), 0);
    chk("rd_exp_q_drained", rd_exp_q.size(), 0);
    chk("spm_exp_q_drained", spm_exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
